// File: rtl/riscv_core_lsu.sv
// Single-outstanding load/store unit: lane steering, byte enables and load extension.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of aligning them down.
module riscv_core_lsu (
  input  logic        i_lsu_clk,
  input  logic        i_lsu_rst,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_memwrite,
  input  logic        i_lsu_memread,
  input  logic [1:0]  i_lsu_size,
  input  logic        i_lsu_ldext,
  input  logic [63:0] i_lsu_addr,
  input  logic [63:0] i_lsu_wdata,
  output logic        o_lsu_ready,
  output logic        o_lsu_mem_req,
  output logic        o_lsu_mem_we,
  output logic [63:0] o_lsu_mem_addr,
  output logic [7:0]  o_lsu_mem_be,
  output logic [63:0] o_lsu_mem_wdata,
  input  logic        i_lsu_mem_gnt,
  input  logic        i_lsu_mem_rvalid,
  input  logic [63:0] i_lsu_mem_rdata,
  output logic        o_lsu_done,
  output logic [63:0] o_lsu_rdata,
  output logic        o_lsu_misaligned
);

`ifdef LSU_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic        store_q;
  logic        zext_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        accept;
  logic        mis;
  logic [2:0]  lo_eff;
  logic [5:0]  shamt;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                              input logic zext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] sx;
    b  = raw[7:0];
    h  = raw[15:0];
    w  = raw[31:0];
    sx = raw;
    case (size)
      2'b00:   if (zext) sx = {56'b0, raw[7:0]};  else sx = b;
      2'b01:   if (zext) sx = {48'b0, raw[15:0]}; else sx = h;
      2'b10:   if (zext) sx = {32'b0, raw[31:0]}; else sx = w;
      default: sx = raw;
    endcase
    return sx;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return |lo[1:0];
      2'b11:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

  assign mis    = is_misaligned(i_lsu_size, i_lsu_addr[2:0]);
  assign lo_eff = i_lsu_addr[2:0];
`else
  // Without the trap, offsets below the access size are silently cleared.
  function automatic logic [2:0] align_lo(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'b01:   return {lo[2:1], 1'b0};
      2'b10:   return {lo[2], 2'b00};
      2'b11:   return 3'b000;
      default: return lo;
    endcase
  endfunction

  assign mis    = 1'b0;
  assign lo_eff = align_lo(i_lsu_size, i_lsu_addr[2:0]);
`endif

  assign accept = (state_q == S_IDLE) & i_lsu_valid & (i_lsu_memwrite | i_lsu_memread);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = mis ? state_t'(S_IDLE + 3'd4) : S_REQ;
      end
      S_REQ:  if (i_lsu_mem_gnt) state_d = store_q ? S_DONE : S_WAIT;
      S_WAIT: if (i_lsu_mem_rvalid) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_lsu_clk) begin
    if (i_lsu_rst) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Request capture: data fields carry no reset, outputs are gated by state.
  always_ff @(posedge i_lsu_clk) begin
    if (accept) begin
      store_q <= i_lsu_memwrite;
      zext_q  <= i_lsu_ldext;
      size_q  <= i_lsu_size;
      addr_q  <= {i_lsu_addr[63:3], lo_eff};
      wdata_q <= i_lsu_wdata;
    end
  end

  assign shamt = {addr_q[2:0], 3'b000};

  always_ff @(posedge i_lsu_clk) begin
    if (i_lsu_rst)
      rdata_q <= '0;
    else if ((state_q == S_WAIT) && i_lsu_mem_rvalid)
      rdata_q <= load_extend(i_lsu_mem_rdata >> shamt, size_q, zext_q);
  end

  assign o_lsu_ready      = (state_q == S_IDLE);
  assign o_lsu_mem_req    = (state_q == S_REQ);
  assign o_lsu_mem_we     = o_lsu_mem_req & store_q;
  assign o_lsu_mem_addr   = o_lsu_mem_req ? {addr_q[63:3], 3'b000} : 64'd0;
  assign o_lsu_mem_be     = o_lsu_mem_req ? (size_mask(size_q) << addr_q[2:0]) : 8'd0;
  assign o_lsu_mem_wdata  = o_lsu_mem_req ? (wdata_q << shamt) : 64'd0;
  assign o_lsu_done       = (state_q == S_DONE);
  assign o_lsu_rdata      = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign o_lsu_misaligned = (state_q == S_ERR);
`else
  assign o_lsu_misaligned = 1'b0;
`endif

endmodule

// File: doc/riscv_core_lsu.md
RISCV_CORE_LSU -- requirements
Module: riscv_core_lsu

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- i_lsu_clk  in  1  clock.
- i_lsu_rst  in  1  reset: one clock, synchronous, active-high.
- i_lsu_valid  in  1  request from execute stage.
- i_lsu_memwrite  in  1  store.
- i_lsu_memread  in  1  load (resultsrc=01).
- i_lsu_size  in  2  00=B, 01=H, 10=W, 11=D.
- i_lsu_ldext  in  1  1=zero-extend, 0=sign-extend.
- i_lsu_addr  in  64  byte address.
- i_lsu_wdata  in  64  store data, LSB-aligned.
- o_lsu_ready  out  1  idle, can accept.
- o_lsu_mem_req  out  1  memory request.
- o_lsu_mem_we  out  1  write enable.
- o_lsu_mem_addr  out  64  doubleword-aligned address (bits[2:0]=0).
- o_lsu_mem_be  out  8  byte enables.
- o_lsu_mem_wdata  out  64  lane-shifted store data.
- i_lsu_mem_gnt  in  1  request accepted.
- i_lsu_mem_rvalid  in  1  read data valid.
- i_lsu_mem_rdata  in  64  read doubleword.
- o_lsu_done  out  1  one-cycle completion pulse.
- o_lsu_rdata  out  64  extended load result.
- o_lsu_misaligned  out  1  one-cycle misalignment pulse.

Function
REQ-002 SHALL implement FSM states IDLE, REQ, WAIT, DONE, ERR.
REQ-003 o_lsu_ready SHALL be 1 only in IDLE; a request is accepted when o_lsu_ready & i_lsu_valid & (memwrite | memread).
REQ-004 Accepted-request fields SHALL be latched; inputs are ignored outside IDLE.
REQ-005 When memwrite and memread are both 1, the request SHALL be treated as a store; when valid is high with neither set, nothing happens.
REQ-006 Misaligned means: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
REQ-007 IDLE, accepted and aligned: go to REQ next cycle.
REQ-008 IDLE, accepted and misaligned: go to ERR; assert o_lsu_misaligned for that one cycle with no memory request; then return to IDLE.
REQ-009 In REQ, o_lsu_mem_req SHALL stay 1 with stable addr/we/be/wdata until i_lsu_mem_gnt.
REQ-010 On gnt in REQ: a store goes to DONE; a load goes to WAIT.
REQ-011 In WAIT, the FSM SHALL go to DONE on i_lsu_mem_rvalid; rvalid is ignored in every other state.
REQ-012 DONE SHALL assert o_lsu_done for one cycle, then return to IDLE.
REQ-013 o_lsu_rdata SHALL be registered on rvalid and held until the next load completes.
REQ-014 Minimum latency with gnt in the first REQ cycle (acceptance = cycle 0):
- store: o_lsu_done in cycle 2.
- load with rvalid in cycle 2: o_lsu_done in cycle 3.
REQ-015 Memory-side fields:
- o_lsu_mem_addr = {addr[63:3], 3'b000}.
- o_lsu_mem_be = (B:0x01, H:0x03, W:0x0F, D:0xFF) << addr[2:0].
- o_lsu_mem_wdata = wdata << (8*addr[2:0]).
REQ-016 Load result: take rdata >> (8*addr[2:0]), then truncate to size. B/H/W are extended per i_lsu_ldext; D passes through unchanged.
REQ-017 o_lsu_mem_we SHALL equal the latched store flag while o_lsu_mem_req=1, and be 0 otherwise.

Reset
REQ-018 When i_lsu_rst=1 at a clock edge, the block SHALL enter IDLE. Output values after reset:
- o_lsu_ready=1.
- o_lsu_rdata=0.
- all other outputs 0.
REQ-019 Reset in REQ or WAIT SHALL abort the access; mem_req drops the next cycle, and a later gnt/rvalid produces no done.

Configuration
REQ-020 Macro LSU_MISALIGN_CHECK_EN:
- defined: REQ-006/REQ-008 apply.
- undefined: o_lsu_misaligned is tied 0, ERR is absent, and addr low bits below size alignment are forced to 0 before REQ-015/REQ-016.

Verification
REQ-021 Store W, addr=0x1004, wdata=0xDEADBEEF, gnt immediate -> mem_addr=0x1000, be=0xF0, wdata=0xDEADBEEF_00000000, done in cycle 2.
REQ-022 Load B signed, addr=0x2003, rdata=0x00000000_80000000 (byte3=0x80) -> o_lsu_rdata=0xFFFFFFFFFFFFFF80; same with ldext=1 -> 0x80.
REQ-023 Load H, addr=0x11 with macro defined -> misaligned pulse in cycle 1, no mem_req, ready=1 in cycle 2; with macro undefined -> access at be=0x03 on doubleword 0x10.
REQ-024 Load D with gnt held off 3 cycles and rvalid 2 cycles later -> req stable throughout, done exactly one cycle after rvalid.
REQ-025 Reset asserted in WAIT, then rvalid pulsed -> no done, ready=1, rdata=0.
